// File: rtl/intc_arb.sv
// Interrupt controller: NMI edge detection, six prioritised peripheral sources,
// register file on the internal bus and the IDLE/ACK/HOLD vector handshake to the CPU.
module intc_arb (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic        NMI_N,
  input  logic        WDT_IRQ,
  input  logic        DIVU_IRQ,
  input  logic        DMA0_IRQ,
  input  logic        DMA1_IRQ,
  input  logic        SCI_IRQ,
  input  logic        FRT_IRQ,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic [31:0] IBUS_DO,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        INT_REQ,
  output logic [3:0]  INT_LEVEL,
  output logic        INT_NMI,
  input  logic        INT_ACK,
  output logic [7:0]  INT_VEC,
  output logic        INT_ACP
);
  localparam int NUM_SRC = 6;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;
  state_t state_q, state_d;

  logic       nmie, nmi_q, nmi_pend;
  logic [3:0] pri_divu, pri_dma, pri_wdt, pri_sci, pri_frt;
  logic [6:0] vec_sci, vec_frt, vec_wdt, vec_divu, vec_dma0, vec_dma1;
  logic [6:0] win_vec_q;

  // register decode on halfword addresses
  logic sel_icr, sel_ipra, sel_iprb, sel_vcr0, sel_vcr1, sel_vcr2;
  assign sel_icr  = ({IBUS_A[31:1], 1'b0} == 32'hFFFF_FEE0);
  assign sel_ipra = ({IBUS_A[31:1], 1'b0} == 32'hFFFF_FEE2);
  assign sel_iprb = ({IBUS_A[31:1], 1'b0} == 32'hFFFF_FE60);
  assign sel_vcr0 = ({IBUS_A[31:1], 1'b0} == 32'hFFFF_FE62);
  assign sel_vcr1 = ({IBUS_A[31:1], 1'b0} == 32'hFFFF_FEE4);
  assign sel_vcr2 = ({IBUS_A[31:1], 1'b0} == 32'hFFFF_FEE6);

  assign IBUS_ACT  = IBUS_REQ & (sel_icr | sel_ipra | sel_iprb | sel_vcr0 | sel_vcr1 | sel_vcr2);
  assign IBUS_BUSY = 1'b0;

  // Either 16-bit half of the bus may carry the write; lanes 1/3 hit [15:8], 0/2 hit [7:0].
  logic        hi_we, lo_we, wr_en;
  logic [15:0] wd;
  assign wd    = (IBUS_BA[1:0] == 2'b00) ? IBUS_DI[31:16] : IBUS_DI[15:0];
  assign hi_we = IBUS_BA[3] | IBUS_BA[1];
  assign lo_we = IBUS_BA[2] | IBUS_BA[0];
  assign wr_en = IBUS_ACT & IBUS_WE;

  logic [15:0] rd;
  always_comb begin
    rd = '0;
    if (sel_icr)  rd = {NMI_N, 6'b0, nmie, 8'b0};
    if (sel_ipra) rd = {pri_divu, pri_dma, pri_wdt, 4'b0};
    if (sel_iprb) rd = {pri_sci, pri_frt, 8'b0};
    if (sel_vcr0) rd = {1'b0, vec_sci, 1'b0, vec_frt};
    if (sel_vcr1) rd = {1'b0, vec_wdt, 1'b0, vec_divu};
    if (sel_vcr2) rd = {1'b0, vec_dma0, 1'b0, vec_dma1};
  end

  // index 0 is the strongest tie-break position
  logic [NUM_SRC-1:0]      irq;
  logic [NUM_SRC-1:0][3:0] src_lvl;
  logic [NUM_SRC-1:0][6:0] src_vec;
  assign irq     = {FRT_IRQ, SCI_IRQ, WDT_IRQ, DMA1_IRQ, DMA0_IRQ, DIVU_IRQ};
  assign src_lvl = {pri_frt, pri_sci, pri_wdt, pri_dma, pri_dma, pri_divu};
  assign src_vec = {vec_frt, vec_sci, vec_wdt, vec_dma1, vec_dma0, vec_divu};

  logic [3:0] best_lvl, arb_lvl;
  logic [6:0] best_vec, arb_vec;
  logic       arb_req;
  always_comb begin
    best_lvl = '0;
    best_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq[i] && (src_lvl[i] > best_lvl)) begin
        best_lvl = src_lvl[i];
        best_vec = src_vec[i];
      end
    end
    arb_req = nmi_pend | (best_lvl != 4'd0);
    arb_lvl = nmi_pend ? 4'd15 : best_lvl;
    arb_vec = nmi_pend ? 7'd11 : best_vec;
  end

  logic nmi_edge;
  assign nmi_edge = nmie ? (~nmi_q & NMI_N) : (nmi_q & ~NMI_N);

  logic accept, arb_en, nmi_clr;
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    arb_en  = 1'b0;
    nmi_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (INT_ACK && INT_REQ) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end else begin
          arb_en = 1'b1;
        end
      end
      S_ACK: begin
        nmi_clr = INT_NMI;
        state_d = S_HOLD;
      end
      S_HOLD:  if (!INT_ACK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign INT_ACP = (state_q == S_ACK);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      {nmie, nmi_pend} <= '0;
      nmi_q <= 1'b1;
      {pri_divu, pri_dma, pri_wdt, pri_sci, pri_frt} <= '0;
      {vec_sci, vec_frt, vec_wdt, vec_divu, vec_dma0, vec_dma1} <= '0;
      {INT_REQ, INT_LEVEL, INT_NMI, win_vec_q, INT_VEC} <= '0;
    end else if (CE_R) begin
      if (!RES_N) begin
        state_q <= S_IDLE;
        {nmie, nmi_pend} <= '0;
        nmi_q <= 1'b1;
        {pri_divu, pri_dma, pri_wdt, pri_sci, pri_frt} <= '0;
        {vec_sci, vec_frt, vec_wdt, vec_divu, vec_dma0, vec_dma1} <= '0;
        {INT_REQ, INT_LEVEL, INT_NMI, win_vec_q, INT_VEC} <= '0;
      end else begin
        state_q  <= state_d;
        nmi_q    <= NMI_N;
        // a fresh edge outranks the clear from an NMI accept
        nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);
        if (arb_en) begin
          INT_REQ   <= arb_req;
          INT_LEVEL <= arb_lvl;
          INT_NMI   <= nmi_pend;
          win_vec_q <= arb_vec;
        end
        if (accept) INT_VEC <= {1'b0, win_vec_q};
        if (wr_en) begin
          if (sel_icr  && hi_we) nmie <= wd[8];
          if (sel_ipra && hi_we) {pri_divu, pri_dma} <= wd[15:8];
          if (sel_ipra && lo_we) pri_wdt <= wd[7:4];
          if (sel_iprb && hi_we) {pri_sci, pri_frt} <= wd[15:8];
          if (sel_vcr0 && hi_we) vec_sci  <= wd[14:8];
          if (sel_vcr0 && lo_we) vec_frt  <= wd[6:0];
          if (sel_vcr1 && hi_we) vec_wdt  <= wd[14:8];
          if (sel_vcr1 && lo_we) vec_divu <= wd[6:0];
          if (sel_vcr2 && hi_we) vec_dma0 <= wd[14:8];
          if (sel_vcr2 && lo_we) vec_dma1 <= wd[6:0];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                IBUS_DO <= '0;
    else if (CE_R && !RES_N)   IBUS_DO <= '0;
    else if (CE_F)             IBUS_DO <= IBUS_ACT ? {rd, rd} : 32'h0;
  end

  logic unused_ok;
  assign unused_ok = ^{IBUS_A[0], wd[7]};
endmodule
